// File: rtl/arbitro_mux_pkg.sv
// Shared types and helpers for the round-robin output-channel arbiter.
// Holds the FSM state encoding and the modulo-N index increment.
package pkg_arbitro;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Wraps explicitly at n-1 so non-power-of-two requester counts stay in range
  function automatic int next_idx(input int idx, input int n);
    if (idx >= n - 1) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/arbitro_mux_seletor_rr.sv
// Rotated priority search: returns the first valid requester at or after ptr,
// wrapping around to index 0 when none is found above ptr.
module seletor_rr
  import pkg_arbitro::*;
#(
  parameter int N = 2,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_valid,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [N-1:0] mask;
  logic [N-1:0] upper;

  // Lowest set bit overall is the wrap-around fallback; a hit at or above ptr wins
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    upper = req_valid & mask;
    found = |req_valid;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        idx = SW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (upper[i]) begin
        idx = SW'(i);
      end
    end
  end

endmodule

// File: rtl/arbitro_mux.sv
// Round-robin arbiter sharing one W-bit valid/ready channel among N requesters;
// a grant is held until the owner transfers a beat marked last.
module arbitro_mux
  import pkg_arbitro::*;
#(
  parameter int N = 2,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_data,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic [SW-1:0]   sel,
  output logic            busy
);

  state_t        state;
  logic [SW-1:0] ptr;
  logic          found;
  logic [SW-1:0] pick;
  logic          xfer;

  seletor_rr #(.N(N)) u_seletor (
    .req_valid (req_valid),
    .ptr       (ptr),
    .found     (found),
    .idx       (pick)
  );

  assign busy = (state == GRANT);
  assign xfer = busy & out_valid & out_ready;

  // Data path follows sel even in IDLE; only the handshake bits are gated by the grant
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = req_data[W-1:0];
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        out_data = req_data[i*W +: W];
        if (state == GRANT) begin
          out_valid    = req_valid[i];
          out_last     = req_last[i];
          req_ready[i] = out_ready;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          // The requester just served drops to lowest priority for the next search
          if (xfer && out_last) begin
            state <= IDLE;
            ptr   <= SW'(next_idx(int'(sel), N));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mux.sv
// Directed bench for arbitro_mux (N=2, W=8): reset, single beat, rotation,
// multi-beat hold, backpressure and mid-packet reset.
module tb_arbitro_mux;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [0:0]  sel;
  logic        busy;

  int vectors;
  int miscompares;

  arbitro_mux #(.N(2), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] v,
                               input logic [15:0] d, input logic [1:0] l,
                               input logic ordy);
    rst       = r;
    req_valid = v;
    req_data  = d;
    req_last  = l;
    out_ready = ordy;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held two cycles with both requesters asking
    applyStimulus(1'b1, 2'b11, 16'h2211, 2'b11, 1'b1);
    for (int c = 0; c < 2; c++) begin
      stepClock();
      checkIdle("rst_hold");
      checkOutput("rst_hold_sel", 32'(sel), 32'd0);
    end
    applyStimulus(1'b0, 2'b11, 16'h2211, 2'b11, 1'b1);
    checkIdle("rst_release");
    checkOutput("rst_release_sel", 32'(sel), 32'd0);
    checkOutput("rst_release_data", 32'(out_data), 32'h11);
    stepClock();
    checkOutput("first_grant_sel", 32'(sel), 32'd0);
    checkOutput("first_grant_busy", 32'(busy), 32'd1);
    checkOutput("first_grant_data", 32'(out_data), 32'h11);
    checkOutput("first_grant_ready", 32'(req_ready), 32'b01);
    stepClock();
    applyStimulus(1'b0, 2'b00, 16'h2211, 2'b00, 1'b1);
    checkIdle("first_done");
    checkOutput("first_done_ptr", 32'(dut.ptr), 32'd1);

    // Single requester, single beat
    applyStimulus(1'b0, 2'b10, 16'hA500, 2'b10, 1'b1);
    checkIdle("single_wait");
    stepClock();
    checkOutput("single_sel", 32'(sel), 32'd1);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_data", 32'(out_data), 32'hA5);
    checkOutput("single_last", 32'(out_last), 32'd1);
    checkOutput("single_ready", 32'(req_ready), 32'b10);
    stepClock();
    applyStimulus(1'b0, 2'b00, 16'hA500, 2'b00, 1'b1);
    checkIdle("single_after");
    checkOutput("single_ptr", 32'(dut.ptr), 32'd0);

    // Round-robin rotation with one bubble after each last beat
    applyStimulus(1'b0, 2'b11, 16'hBBAA, 2'b11, 1'b1);
    for (int g = 0; g < 4; g++) begin
      stepClock();
      checkOutput("rr_busy", 32'(busy), 32'd1);
      checkOutput("rr_sel", 32'(sel), 32'(g % 2));
      checkOutput("rr_data", 32'(out_data), (g % 2 == 0) ? 32'hAA : 32'hBB);
      stepClock();
      checkIdle("rr_bubble");
    end

    // Multi-beat hold on requester 0 while requester 1 waits
    applyStimulus(1'b0, 2'b11, 16'h7701, 2'b00, 1'b1);
    stepClock();
    checkOutput("mb_sel", 32'(sel), 32'd0);
    checkOutput("mb_b1_data", 32'(out_data), 32'h01);
    checkOutput("mb_b1_ready", 32'(req_ready), 32'b01);
    checkOutput("mb_b1_last", 32'(out_last), 32'd0);
    stepClock();
    applyStimulus(1'b0, 2'b11, 16'h7702, 2'b00, 1'b1);
    checkOutput("mb_b2_data", 32'(out_data), 32'h02);
    checkOutput("mb_b2_ready", 32'(req_ready), 32'b01);
    checkOutput("mb_b2_sel", 32'(sel), 32'd0);
    stepClock();
    applyStimulus(1'b0, 2'b11, 16'h7703, 2'b01, 1'b1);
    checkOutput("mb_b3_data", 32'(out_data), 32'h03);
    checkOutput("mb_b3_last", 32'(out_last), 32'd1);
    checkOutput("mb_b3_ready", 32'(req_ready), 32'b01);
    stepClock();
    checkIdle("mb_bubble");
    stepClock();
    checkOutput("mb_next_sel", 32'(sel), 32'd1);
    checkOutput("mb_next_busy", 32'(busy), 32'd1);
    checkOutput("mb_next_data", 32'(out_data), 32'h77);

    // Backpressure on requester 1
    applyStimulus(1'b0, 2'b10, 16'h5C00, 2'b10, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_data", 32'(out_data), 32'h5C);
      checkOutput("bp_ready", 32'(req_ready), 32'b00);
      checkOutput("bp_sel", 32'(sel), 32'd1);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      stepClock();
    end
    applyStimulus(1'b0, 2'b10, 16'h5C00, 2'b10, 1'b1);
    checkOutput("bp_release_ready", 32'(req_ready), 32'b10);
    checkOutput("bp_release_data", 32'(out_data), 32'h5C);
    stepClock();
    checkIdle("bp_done");
    checkOutput("bp_done_ptr", 32'(dut.ptr), 32'd0);

    // Mid-packet reset after the first beat of a requester 1 packet
    applyStimulus(1'b0, 2'b10, 16'hC100, 2'b00, 1'b1);
    stepClock();
    checkOutput("mpr_grant_sel", 32'(sel), 32'd1);
    checkOutput("mpr_beat1_data", 32'(out_data), 32'hC1);
    stepClock();
    applyStimulus(1'b1, 2'b11, 16'hC20D, 2'b00, 1'b1);
    stepClock();
    checkIdle("mpr_reset");
    checkOutput("mpr_reset_sel", 32'(sel), 32'd0);
    checkOutput("mpr_reset_ptr", 32'(dut.ptr), 32'd0);
    applyStimulus(1'b0, 2'b11, 16'hC20D, 2'b00, 1'b1);
    stepClock();
    checkOutput("mpr_rearb_sel", 32'(sel), 32'd0);
    checkOutput("mpr_rearb_data", 32'(out_data), 32'h0D);
    checkOutput("mpr_rearb_ready", 32'(req_ready), 32'b01);

    applyStimulus(1'b0, 2'b00, 16'h0000, 2'b00, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arbitro_mux.md
Name: arbitro_mux

Overview:
- Round-robin arbiter that shares one W-bit output channel between N requesters.
- Owns the select of the N:1 data mux and sequences packet ownership with valid/ready handshakes.
- A grant is held until the granted requester completes a packet, marked by `last`.
- Sits between producer blocks and the single downstream consumer; the internal mux is the shared resource.

Parameters:
- N, 2, number of requesters (≥2).
- W, 8, data width per requester.
- SW, $clog2(N) (min 1), select width; derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N  per-requester valid.
- req_data  in  N*W  requester i data at bits [i*W +: W].
- req_last  in  N  per-requester end-of-packet marker.
- req_ready  out  N  per-requester ready; at most one bit high.
- out_valid  out  1  output channel valid.
- out_data  out  W  output channel data.
- out_last  out  1  output end-of-packet marker.
- out_ready  in  1  downstream ready.
- sel  out  SW  current mux select (registered).
- busy  out  1  high while a grant is held (state GRANT).

Behaviour:
- State machine has two states, IDLE and GRANT.
- Registers: state, sel, and ptr (round-robin start index, SW bits).
- Reset (rst=1 at an edge) forces state=IDLE, sel=0, ptr=0. Combinationally this gives busy=0, out_valid=0, out_last=0, req_ready=0, and out_data=req_data[0] (don't-care while out_valid=0).
- Reset mid-packet abandons the packet. There is no flush and no recovery of the partial packet.
- IDLE:
  - req_ready=0 and out_valid=0.
  - If any req_valid bit is set, pick the first index i with req_valid[i]=1, searching ptr, ptr+1, … modulo N.
  - At the next edge: sel←i, state←GRANT.
  - If no req_valid bit is set, stay in IDLE.
- GRANT (combinational outputs):
  - out_valid=req_valid[sel], out_data=req_data[sel], out_last=req_last[sel].
  - req_ready[sel]=out_ready; all other req_ready bits are 0.
- A transfer occurs in any GRANT cycle with out_valid & out_ready.
  - Transfer with out_last=1: at the next edge state←IDLE, ptr←(sel+1) mod N. When N is not a power of 2, wrap from N-1 to 0 explicitly.
  - Transfer with out_last=0, or no transfer: stay in GRANT with sel unchanged.
- Latency:
  - 1 cycle from the first req_valid in IDLE to grant.
  - 1 idle bubble cycle after every last beat, before the next arbitration. There is no back-to-back re-grant.
- Fairness:
  - The requester just served has lowest priority in the next arbitration.
  - With all N requesters continuously valid, grants rotate 0,1,…,N-1,0.
- Simultaneous events:
  - Requests from non-granted requesters during GRANT are ignored; they see req_ready=0 and must hold their data.
  - A single-beat packet (req_last=1 on the first beat) is legal and holds the grant for one transfer only.
  - If the granted requester drops req_valid mid-packet, the grant is kept: out_valid=0 and the arbiter waits. There is no timeout.
- Out-of-range requesters: indices ≥ N never exist, and sel is always < N.

Decomposition:
- Shared package (pkg_arbitro):
  - State enum: IDLE=1'b0, GRANT=1'b1.
  - Helper function next_idx(idx, N) for the modulo-N increment.
- One sub-module, seletor_rr: purely combinational.
  - Inputs: req_valid[N], ptr[SW].
  - Outputs: found (1), idx (SW).
  - Function: rotated priority search starting at ptr.
- The data mux is an inline indexed part-select on req_data using sel. No separate instance.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with req_valid=2'b11. Required: busy=0, out_valid=0, req_ready=2'b00, sel=0 on every cycle of reset and the cycle after release.
- Single requester, single beat: N=2, W=8, req_valid=2'b10, req_data[15:8]=8'hA5, req_last=2'b10, out_ready=1. Required: one cycle later sel=1, out_valid=1, out_data=8'hA5, out_last=1, req_ready=2'b10; the following cycle is IDLE with ptr=0.
- Round-robin rotation: both requesters always valid, every beat last, out_ready=1. Required: grants alternate sel=0,1,0,1, with one idle bubble between each transfer.
- Multi-beat hold: requester 0 sends 3 beats 8'h01, 8'h02, 8'h03 with last on the third, while requester 1 is valid throughout. Required: req_ready[1]=0 for all 3 beats; grant moves to sel=1 only after the 8'h03 transfer plus one idle cycle.
- Backpressure: during a grant, out_ready=0 for 3 cycles with req_valid[sel]=1 and data 8'h5C. Required: out_data holds 8'h5C, req_ready=0, sel is unchanged, and there is no state change; the transfer completes on the first cycle with out_ready=1.
- Mid-packet reset: assert rst for 1 cycle after beat 1 of a 3-beat packet from requester 1. Required: next cycle state=IDLE, sel=0, ptr=0, and re-arbitration starts from requester 0.
